// File: rtl/alarm_ring_pkg.sv
// Shared alarm_ring definitions: state encodings, BCD digit width and a
// small helper used when sizing the second counters.
package alarm_ring_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alarm_tone.sv
// Buzzer square-wave generator; the divider restarts from zero whenever
// enable drops, so each enable period starts with a full half-period low.
module alarm_tone #(
  parameter int CLK_HZ  = 50000000,
  parameter int TONE_HZ = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic buzzer
);

  localparam int HALF  = CLK_HZ / (2 * TONE_HZ);
  localparam int DIV_W = (HALF > 1) ? $clog2(HALF + 1) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tone_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      tone_q  <= 1'b0;
    end else if (!enable) begin
      div_cnt <= '0;
      tone_q  <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      tone_q  <= ~tone_q;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Gate with enable so the buzzer goes quiet on the same edge ringing drops.
  assign buzzer = tone_q & enable;

endmodule

// File: rtl/alarm_ring.sv
// Alarm controller: detects the alarm time, rings, handles snooze/stop and
// drives the buzzer through alarm_tone.
module alarm_ring
  import alarm_ring_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int TONE_HZ    = 1000,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_1hz,
  input  logic               alarm_en,
  input  logic [DIGIT_W-1:0] cur_secL,
  input  logic [DIGIT_W-1:0] cur_secH,
  input  logic [DIGIT_W-1:0] cur_minL,
  input  logic [DIGIT_W-1:0] cur_minH,
  input  logic [DIGIT_W-1:0] cur_hourL,
  input  logic [DIGIT_W-1:0] cur_hourH,
  input  logic [DIGIT_W-1:0] alarm_secL,
  input  logic [DIGIT_W-1:0] alarm_secH,
  input  logic [DIGIT_W-1:0] alarm_minL,
  input  logic [DIGIT_W-1:0] alarm_minH,
  input  logic [DIGIT_W-1:0] alarm_hourL,
  input  logic [DIGIT_W-1:0] alarm_hourH,
  input  logic               stop_pulse,
  input  logic               snooze_pulse,
  output logic               buzzer,
  output logic               ringing,
  output logic               snoozing,
  output logic [1:0]         snooze_left
);

  localparam int CNT_W = $clog2(max_int(RING_SEC, SNOOZE_SEC) + 1);
  localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_SEC - 1);
  localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_SEC - 1);

  state_t           state;
  logic [CNT_W-1:0] sec_cnt;
  logic             match;
  logic             prev_match;
  logic             armed;
  logic             trigger;

  assign match = (cur_secL  == alarm_secL)  && (cur_secH  == alarm_secH)  &&
                 (cur_minL  == alarm_minL)  && (cur_minH  == alarm_minH)  &&
                 (cur_hourL == alarm_hourL) && (cur_hourH == alarm_hourH);

  // armed blocks a spurious trigger on the first clk after reset release.
  assign trigger = match && !prev_match && armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sec_cnt     <= '0;
      snooze_left <= '0;
      ringing     <= 1'b0;
      snoozing    <= 1'b0;
      prev_match  <= 1'b0;
      armed       <= 1'b0;
    end else begin
      prev_match <= match;
      armed      <= 1'b1;
      case (state)
        IDLE: begin
          if (trigger && alarm_en) begin
            state       <= RING;
            ringing     <= 1'b1;
            snooze_left <= 2'(MAX_SNOOZE);
            sec_cnt     <= '0;
          end
        end
        RING: begin
          // Stop beats snooze, snooze beats the ring timeout.
          if (stop_pulse || !alarm_en) begin
            state   <= IDLE;
            ringing <= 1'b0;
          end else if (snooze_pulse && snooze_left != 2'd0) begin
            state       <= SNOOZE;
            ringing     <= 1'b0;
            snoozing    <= 1'b1;
            snooze_left <= snooze_left - 2'd1;
            sec_cnt     <= '0;
          end else if (tick_1hz) begin
            if (sec_cnt >= RING_LAST) begin
              state   <= IDLE;
              ringing <= 1'b0;
            end else if (sec_cnt != '1) begin
              sec_cnt <= sec_cnt + 1'b1;
            end
          end
        end
        SNOOZE: begin
          if (stop_pulse || !alarm_en) begin
            state    <= IDLE;
            snoozing <= 1'b0;
          end else if (tick_1hz) begin
            if (sec_cnt >= SNOOZE_LAST) begin
              state    <= RING;
              ringing  <= 1'b1;
              snoozing <= 1'b0;
              sec_cnt  <= '0;
            end else if (sec_cnt != '1) begin
              sec_cnt <= sec_cnt + 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          ringing  <= 1'b0;
          snoozing <= 1'b0;
        end
      endcase
    end
  end

  alarm_tone #(
    .CLK_HZ (CLK_HZ),
    .TONE_HZ(TONE_HZ)
  ) u_tone (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(ringing),
    .buzzer(buzzer)
  );

endmodule

// File: tb/tb_alarm_ring.sv
// Directed bench for alarm_ring with small parameters (10-clk tone period,
// 5 s ring, 3 s snooze, 2 snoozes).
module tb_alarm_ring;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_1hz;
  logic       alarm_en;
  logic [3:0] cur_secL, cur_secH, cur_minL, cur_minH, cur_hourL, cur_hourH;
  logic [3:0] alarm_secL, alarm_secH, alarm_minL, alarm_minH, alarm_hourL, alarm_hourH;
  logic       stop_pulse;
  logic       snooze_pulse;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic [1:0] snooze_left;

  int total = 0;
  int bad   = 0;

  alarm_ring #(
    .CLK_HZ    (1000),
    .TONE_HZ   (100),
    .RING_SEC  (5),
    .SNOOZE_SEC(3),
    .MAX_SNOOZE(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_1hz    (tick_1hz),
    .alarm_en    (alarm_en),
    .cur_secL    (cur_secL),
    .cur_secH    (cur_secH),
    .cur_minL    (cur_minL),
    .cur_minH    (cur_minH),
    .cur_hourL   (cur_hourL),
    .cur_hourH   (cur_hourH),
    .alarm_secL  (alarm_secL),
    .alarm_secH  (alarm_secH),
    .alarm_minL  (alarm_minL),
    .alarm_minH  (alarm_minH),
    .alarm_hourL (alarm_hourL),
    .alarm_hourH (alarm_hourH),
    .stop_pulse  (stop_pulse),
    .snooze_pulse(snooze_pulse),
    .buzzer      (buzzer),
    .ringing     (ringing),
    .snoozing    (snoozing),
    .snooze_left (snooze_left)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cur(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    cur_hourH = h[7:4]; cur_hourL = h[3:0];
    cur_minH  = m[7:4]; cur_minL  = m[3:0];
    cur_secH  = s[7:4]; cur_secL  = s[3:0];
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
  endtask

  // 07:29:59 -> 07:30:00 produces one rising edge of match.
  task automatic retrigger();
    set_cur(8'h07, 8'h29, 8'h59);
    step();
    set_cur(8'h07, 8'h30, 8'h00);
    step();
  endtask

  initial begin
    rst_n = 1'b0; tick_1hz = 1'b0; alarm_en = 1'b1;
    stop_pulse = 1'b0; snooze_pulse = 1'b0;
    alarm_hourH = 4'd0; alarm_hourL = 4'd7; alarm_minH = 4'd3;
    alarm_minL  = 4'd0; alarm_secH  = 4'd0; alarm_secL = 4'd0;
    set_cur(8'h07, 8'h29, 8'h59);
    step(2);
    check("rst_ringing", {7'd0, ringing}, 8'd0);
    check("rst_snoozing", {7'd0, snoozing}, 8'd0);
    check("rst_buzzer", {7'd0, buzzer}, 8'd0);
    check("rst_left", {6'd0, snooze_left}, 8'd0);
    rst_n = 1'b1;
    step(2);

    // Trigger and tone period
    set_cur(8'h07, 8'h30, 8'h00);
    step();
    check("trig_ringing", {7'd0, ringing}, 8'd1);
    check("trig_left", {6'd0, snooze_left}, 8'd2);
    check("buz_entry", {7'd0, buzzer}, 8'd0);
    step(4);
    check("buz_before_half", {7'd0, buzzer}, 8'd0);
    step();
    check("buz_first_toggle", {7'd0, buzzer}, 8'd1);
    step(4);
    check("buz_high_hold", {7'd0, buzzer}, 8'd1);
    step();
    check("buz_second_toggle", {7'd0, buzzer}, 8'd0);

    // Ring timeout with match held
    for (int i = 0; i < 4; i++) tick();
    check("ring_after_4_ticks", {7'd0, ringing}, 8'd1);
    tick();
    check("timeout_ringing", {7'd0, ringing}, 8'd0);
    step(3);
    check("no_retrigger", {7'd0, ringing}, 8'd0);
    check("timeout_buzzer", {7'd0, buzzer}, 8'd0);

    // Two snoozes then an ignored third
    retrigger();
    check("re_ringing", {7'd0, ringing}, 8'd1);
    snooze_pulse = 1'b1; step(); snooze_pulse = 1'b0;
    check("snz1_snoozing", {7'd0, snoozing}, 8'd1);
    check("snz1_ringing", {7'd0, ringing}, 8'd0);
    check("snz1_left", {6'd0, snooze_left}, 8'd1);
    check("snz1_buzzer", {7'd0, buzzer}, 8'd0);
    tick(); tick();
    check("snz1_2ticks", {7'd0, snoozing}, 8'd1);
    tick();
    check("snz1_back_ring", {7'd0, ringing}, 8'd1);
    check("snz1_back_snz", {7'd0, snoozing}, 8'd0);
    snooze_pulse = 1'b1; step(); snooze_pulse = 1'b0;
    check("snz2_left", {6'd0, snooze_left}, 8'd0);
    check("snz2_snoozing", {7'd0, snoozing}, 8'd1);
    for (int i = 0; i < 3; i++) tick();
    check("snz2_back_ring", {7'd0, ringing}, 8'd1);
    snooze_pulse = 1'b1; step(); snooze_pulse = 1'b0;
    check("snz3_ignored_ring", {7'd0, ringing}, 8'd1);
    check("snz3_ignored_snz", {7'd0, snoozing}, 8'd0);
    stop_pulse = 1'b1; step(); stop_pulse = 1'b0;
    check("stop_ringing", {7'd0, ringing}, 8'd0);

    // Stop and snooze together with snoozes left
    retrigger();
    check("both_pre_ring", {7'd0, ringing}, 8'd1);
    stop_pulse = 1'b1; snooze_pulse = 1'b1; step();
    stop_pulse = 1'b0; snooze_pulse = 1'b0;
    check("both_ringing", {7'd0, ringing}, 8'd0);
    check("both_snoozing", {7'd0, snoozing}, 8'd0);
    check("both_left", {6'd0, snooze_left}, 8'd2);
    check("both_buzzer", {7'd0, buzzer}, 8'd0);

    // Timeout and snooze in the same clk, then disarm in SNOOZE
    retrigger();
    for (int i = 0; i < 4; i++) tick();
    snooze_pulse = 1'b1; tick(); snooze_pulse = 1'b0;
    check("tmo_snz_snoozing", {7'd0, snoozing}, 8'd1);
    check("tmo_snz_left", {6'd0, snooze_left}, 8'd1);
    alarm_en = 1'b0; step();
    check("dis_snz_snoozing", {7'd0, snoozing}, 8'd0);
    check("dis_snz_ringing", {7'd0, ringing}, 8'd0);

    // Disarmed at match, then re-armed while match held
    retrigger();
    check("dis_match_ringing", {7'd0, ringing}, 8'd0);
    alarm_en = 1'b1; step(2);
    check("rearm_held_ringing", {7'd0, ringing}, 8'd0);

    // Reset mid-RING, released while match=1
    retrigger();
    step(6);
    check("pre_rst_buzzer", {7'd0, buzzer}, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ringing", {7'd0, ringing}, 8'd0);
    check("async_rst_buzzer", {7'd0, buzzer}, 8'd0);
    #3 rst_n = 1'b1;
    step(3);
    check("post_rst_no_trig", {7'd0, ringing}, 8'd0);
    check("post_rst_left", {6'd0, snooze_left}, 8'd0);
    retrigger();
    check("post_rst_retrig", {7'd0, ringing}, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alarm_ring.md
ALARM_RING -- requirements
Module: alarm_ring

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- CLK_HZ, 50000000, clk frequency in Hz.
- TONE_HZ, 1000, buzzer square-wave frequency in Hz.
- RING_SEC, 60, maximum ring duration in seconds.
- SNOOZE_SEC, 300, snooze delay in seconds.
- MAX_SNOOZE, 3, snoozes allowed per alarm event.
REQ-002 Ports SHALL be, one per line: name direction width meaning.
- clk input 1 system clock, single clock domain.
- rst_n input 1 asynchronous active-low reset.
- tick_1hz input 1 one-clk pulse per second from the timekeeper.
- alarm_en input 1 alarm armed; 0 disarms.
- cur_secL/cur_secH/cur_minL/cur_minH/cur_hourL/cur_hourH input 4 each current time BCD digits.
- alarm_secL/alarm_secH/alarm_minL/alarm_minH/alarm_hourL/alarm_hourH input 4 each stored alarm BCD digits.
- stop_pulse input 1 debounced one-clk stop request.
- snooze_pulse input 1 debounced one-clk snooze request.
- buzzer output 1 tone square wave, 0 when silent.
- ringing output 1 high while in RING.
- snoozing output 1 high while in SNOOZE.
- snooze_left output 2 snoozes remaining in current event.
REQ-003 Clock port SHALL be clk; reset port SHALL be rst_n, asynchronous, active-low.

Function
REQ-004 match SHALL be 1 when all six cur digits equal the corresponding alarm digits.
REQ-005 trigger SHALL be the rising edge of match (match=1, registered previous match=0), so one matching second yields exactly one trigger.
REQ-006 FSM states SHALL be IDLE, RING, SNOOZE.
REQ-007 IDLE -> RING on trigger with alarm_en=1; snooze_left loaded with MAX_SNOOZE, ring second counter cleared.
REQ-008 RING -> IDLE on stop_pulse, on alarm_en=0, or when the ring counter reaches RING_SEC tick_1hz pulses.
REQ-009 RING -> SNOOZE on snooze_pulse when snooze_left>0; snooze_left decrements by 1; snooze counter cleared.
REQ-010 snooze_pulse in RING with snooze_left=0 SHALL be ignored.
REQ-011 SNOOZE -> RING after SNOOZE_SEC tick_1hz pulses; ring counter cleared.
REQ-012 SNOOZE -> IDLE on stop_pulse or alarm_en=0.
REQ-013 stop_pulse and snooze_pulse in the same clk in RING: stop SHALL win.
REQ-014 Ring timeout and snooze_pulse in the same clk: snooze SHALL win if snooze_left>0.
REQ-015 trigger while in RING or SNOOZE SHALL be ignored.
REQ-016 State transitions SHALL take effect on the clk edge after the causing input; ringing/snoozing SHALL be registered decodes of state.
REQ-017 buzzer SHALL toggle every CLK_HZ/(2*TONE_HZ) clks while in RING and be forced 0 elsewhere.
REQ-018 The tone divider SHALL restart from 0 on RING entry, so the first toggle comes exactly one half-period after entry.
REQ-019 Second counters SHALL be wide enough for max(RING_SEC, SNOOZE_SEC) and saturate, never wrap.

Reset
REQ-020 rst_n=0 SHALL asynchronously force state=IDLE, buzzer=0, ringing=0, snoozing=0, snooze_left=0, all counters and the previous-match register to 0.
REQ-021 Reset mid-RING or mid-SNOOZE SHALL silence immediately.
REQ-022 After release, the previous-match register SHALL load match on the first clk without generating a trigger.

Structure
REQ-023 A shared header SHALL hold the state encodings (IDLE=0, RING=1, SNOOZE=2) and the BCD digit width constant (4).
REQ-024 Tone generation SHALL be one sub-module, alarm_tone (inputs clk, rst_n, enable; output buzzer; parameters CLK_HZ, TONE_HZ).

Verification
Bench parameters: CLK_HZ=1000, TONE_HZ=100, RING_SEC=5, SNOOZE_SEC=3, MAX_SNOOZE=2.
REQ-025 Alarm 07:30:00, alarm_en=1, cur steps 07:29:59 -> 07:30:00 -> ringing=1 next clk, snooze_left=2; buzzer period 10 clks.
REQ-026 Ringing with no input -> ringing=0 after the 5th tick_1hz; held match gives no retrigger.
REQ-027 Two snooze_pulse, each during RING -> SNOOZE 3 ticks then RING, snooze_left 2->1->0; a third snooze_pulse is ignored.
REQ-028 stop_pulse and snooze_pulse in the same clk during RING -> IDLE, buzzer=0.
REQ-029 alarm_en=0 at match -> stays IDLE; alarm_en dropped in SNOOZE -> IDLE.
REQ-030 rst_n pulsed low mid-RING, released while match=1 -> all outputs 0, no trigger until the next match rising edge.
